writeback_regfile: RTL

Writeback stage plus architectural register file for the pipelined MIPS datapath, consuming the registered outputs of the MEM/WB pipeline register. Selects the writeback value (ALU result, memory word, extended byte/halfword, or link address for `jal`) and destination register. Commits it to a 32×32 register file on the rising clock edge. Also serves the decode stage's two combinational read ports with same-cycle write-through bypass.

---
 rtl/wb_pkg.sv | 15 +
 rtl/writeback_mux.sv | 50 +++++
 rtl/writeback_regfile.sv | 88 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: writeback source encodings
// and the architecturally fixed register numbers.
package wb_pkg;

  typedef enum logic [1:0] {
    MEMTOREG_ALU  = 2'b00,
    MEMTOREG_MEM  = 2'b01,
    MEMTOREG_BYTE = 2'b10,
    MEMTOREG_HALF = 2'b11
  } memtoreg_e;

  localparam logic [4:0] JAL_LINK_REG = 5'd31;
  localparam logic [4:0] ZERO_REG     = 5'd0;

endpackage

// File: rtl/writeback_mux.sv
// Combinational writeback select: picks the writeback value and destination
// register, and qualifies the write enable so that r0 is never written.
//   i_reg_write    : write request from MEM/WB
//   i_mem_to_reg   : source select (ALU / memory / byte / halfword)
//   i_jal_sel      : link write, forces data = PC+4 path and dest = r31
//   i_dest_reg     : destination from MEM/WB
//   i_alu .. i_pc  : candidate writeback values
//   o_write_data   : selected value
//   o_write_reg    : effective destination
//   o_write_en     : effective write enable
module writeback_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_reg_write,
  input  logic [1:0]        i_mem_to_reg,
  input  logic              i_jal_sel,
  input  logic [ADDR_W-1:0] i_dest_reg,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_byte,
  input  logic [DATA_W-1:0] i_half,
  input  logic [DATA_W-1:0] i_pc,
  output logic [DATA_W-1:0] o_write_data,
  output logic [ADDR_W-1:0] o_write_reg,
  output logic              o_write_en
);

  logic [DATA_W-1:0] w_src;

  always_comb begin
    w_src = i_alu;
    case (memtoreg_e'(i_mem_to_reg))
      MEMTOREG_ALU:  w_src = i_alu;
      MEMTOREG_MEM:  w_src = i_mem;
      MEMTOREG_BYTE: w_src = i_byte;
      MEMTOREG_HALF: w_src = i_half;
      default:       w_src = i_alu;
    endcase
  end

  always_comb begin
    o_write_data = i_jal_sel ? i_pc : w_src;
    o_write_reg  = i_jal_sel ? ADDR_W'(JAL_LINK_REG) : i_dest_reg;
    o_write_en   = i_reg_write && (o_write_reg != ADDR_W'(ZERO_REG));
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus architectural register file. Commits the selected
// writeback value on the rising edge, serves two combinational read ports
// with same-cycle write-through bypass, and counts committed writes.
//   Clk, Reset            : clock, async active-low reset
//   RegWriteIn .. PCAddResultIn : MEM/WB pipeline register outputs
//   ReadReg1/2, ReadData1/2     : decode-stage read ports
//   WriteDataOut/RegOut/EnOut   : effective write, for forwarding
//   WriteCount                  : number of committed writes (wraps)
module writeback_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWriteIn,
  input  logic [1:0]        MemToRegIn,
  input  logic              JalMuxSelIn,
  input  logic [ADDR_W-1:0] Mux1In,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [DATA_W-1:0] ReadDataMemIn,
  input  logic [DATA_W-1:0] ExtendedByteIn,
  input  logic [DATA_W-1:0] ExtendedHalfwordIn,
  input  logic [DATA_W-1:0] PCAddResultIn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [ADDR_W-1:0] WriteRegOut,
  output logic              WriteEnOut,
  output logic [31:0]       WriteCount
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [31:0]       r_write_count;
  logic              w_bypass_en;

  writeback_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_writeback_mux (
    .i_reg_write  (RegWriteIn),
    .i_mem_to_reg (MemToRegIn),
    .i_jal_sel    (JalMuxSelIn),
    .i_dest_reg   (Mux1In),
    .i_alu        (ALUResultIn),
    .i_mem        (ReadDataMemIn),
    .i_byte       (ExtendedByteIn),
    .i_half       (ExtendedHalfwordIn),
    .i_pc         (PCAddResultIn),
    .o_write_data (WriteDataOut),
    .o_write_reg  (WriteRegOut),
    .o_write_en   (WriteEnOut)
  );

  // r0 is never written (WriteEnOut excludes it), so it stays at its reset 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_write_count <= '0;
    end else if (WriteEnOut) begin
      r_regs[WriteRegOut] <= WriteDataOut;
      r_write_count       <= r_write_count + 32'd1;
    end
  end

  // Bypass is suppressed while in reset so the read ports show the cleared file.
  assign w_bypass_en = WriteEnOut && Reset;

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadReg1 != ADDR_W'(ZERO_REG)) begin
      ReadData1 = (w_bypass_en && (ReadReg1 == WriteRegOut)) ? WriteDataOut : r_regs[ReadReg1];
    end
    if (ReadReg2 != ADDR_W'(ZERO_REG)) begin
      ReadData2 = (w_bypass_en && (ReadReg2 == WriteRegOut)) ? WriteDataOut : r_regs[ReadReg2];
    end
  end

  assign WriteCount = r_write_count;

endmodule
